// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the sram-like bus arbiter: source ids, FSM states,
// bus field widths and the tracking-FIFO entry layout.
package sram_arbiter_pkg;

  localparam int SIZE_W = 2;
  localparam int STRB_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic src;
    logic cancelled;
  } track_entry_t;

endpackage

// File: rtl/sram_arbiter_track_fifo.sv
// In-order record of accepted transactions ({src, cancelled}) used to route
// each downstream data_ok back to its requester. A bulk cancel input marks
// every instruction entry (including one pushed in the same cycle) as stale.
module arb_track_fifo
  import sram_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_src,
  input  logic                     pop,
  input  logic                     cancel_inst,
  output track_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  track_entry_t           mem_q [DEPTH];
  track_entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [PTR_W:0]         count_q, count_d;

  // Next entry contents, pointers and occupancy; cancel applies to every inst slot
  // (a stale flag on an unused slot is harmless since a push overwrites it).
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cancel_inst && (mem_q[i].src == SRC_INST)) begin
        mem_d[i].cancelled = 1'b1;
      end
    end
    if (push) begin
      mem_d[wptr_q].src       = push_src;
      mem_d[wptr_q].cancelled = cancel_inst && (push_src == SRC_INST);
    end
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  // Entry storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers; reset discards all outstanding entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one sram-like port between instruction fetch and the data stage.
// Data has priority unless fetch has been starved MAX_STARVE times in a row;
// the chosen source stays locked until its address handshake, and responses
// are routed in order through a small tracking FIFO.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int MAX_STARVE  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  localparam int STARVE_W = ($clog2(MAX_STARVE + 1) < 2) ? 2 : $clog2(MAX_STARVE + 1);
  localparam int CNT_W    = $clog2(OUTSTANDING) + 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);
  localparam logic [CNT_W-1:0]    CNT_LIMIT  = CNT_W'(OUTSTANDING);

  arb_state_e           state_q, state_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  logic                 resp_err_q, resp_err_d;
  logic                 sel_src;
  logic                 addr_hs;
  logic                 fifo_pop;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  track_entry_t         fifo_head;

  // Source selection, mem_req and next FSM state; a pending pop does not free a slot this cycle.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    sel_src = SRC_DATA;
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_count < CNT_LIMIT) begin
          if (data_req && (starve_q < STARVE_MAX)) begin
            mem_req = 1'b1;
            sel_src = SRC_DATA;
          end else if (inst_req) begin
            mem_req = 1'b1;
            sel_src = SRC_INST;
          end else if (data_req) begin
            mem_req = 1'b1;
            sel_src = SRC_DATA;
          end
        end
        if (mem_req && !mem_addr_ok) begin
          if (sel_src == SRC_INST) state_d = ST_LOCK_I;
          else                     state_d = ST_LOCK_D;
        end
      end
      ST_LOCK_I: begin
        mem_req = 1'b1;
        sel_src = SRC_INST;
        if (mem_addr_ok) state_d = ST_IDLE;
      end
      ST_LOCK_D: begin
        mem_req = 1'b1;
        sel_src = SRC_DATA;
        if (mem_addr_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign addr_hs      = mem_req && mem_addr_ok;
  assign inst_addr_ok = addr_hs && (sel_src == SRC_INST);
  assign data_addr_ok = addr_hs && (sel_src == SRC_DATA);

  assign mem_wr    = (sel_src == SRC_INST) ? inst_wr    : data_wr;
  assign mem_size  = (sel_src == SRC_INST) ? inst_size  : data_size;
  assign mem_addr  = (sel_src == SRC_INST) ? inst_addr  : data_addr;
  assign mem_wstrb = (sel_src == SRC_INST) ? inst_wstrb : data_wstrb;
  assign mem_wdata = (sel_src == SRC_INST) ? inst_wdata : data_wdata;

  // Starvation counter: counts data grants that overtook a waiting fetch, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!inst_req || (addr_hs && (sel_src == SRC_INST))) begin
      starve_d = '0;
    end else if (addr_hs && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // A response with nothing outstanding is a protocol error that sticks until reset.
  always_comb begin
    resp_err_d = resp_err_q | (mem_data_ok && fifo_empty);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_err = resp_err_q;
  assign fifo_pop = mem_data_ok && !fifo_empty;

  arb_track_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_track (
    .clk        (clk),
    .rst        (rst),
    .push       (addr_hs),
    .push_src   (sel_src),
    .pop        (fifo_pop),
    .cancel_inst(inst_cancel),
    .head       (fifo_head),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

  assign inst_data_ok = fifo_pop && (fifo_head.src == SRC_INST) &&
                        !fifo_head.cancelled && !inst_cancel;
  assign data_data_ok = fifo_pop && (fifo_head.src == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus a randomized run, all checked
// cycle by cycle against a queue-based reference model of the arbitration rules.
module tb_sram_arbiter;

  localparam int OUTSTANDING = 4;
  localparam int MAX_STARVE  = 3;
  localparam int SI = 0;
  localparam int SD = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 0, inst_wr = 0, inst_cancel = 0;
  logic [1:0]  inst_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic [3:0]  inst_wstrb = 0;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic [3:0]  data_wstrb = 0;
  logic        mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        resp_err;

  sram_arbiter #(.OUTSTANDING(OUTSTANDING), .MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int mq_src[$];
  bit mq_canc[$];
  int m_lock = -1;
  int m_starve = 0;
  bit m_err = 0;
  bit i_pend = 0, d_pend = 0;
  int obs_hist[$];
  bit obs_iok, obs_dok, obs_iaok, obs_daok;

  // Stimulus knobs (percent probabilities)
  int unsigned p_inst = 0, p_data = 0, p_aok = 0, p_dok = 0, p_cancel = 0;
  bit force_dok = 0;
  bit use_fix = 0;
  logic [31:0] fix_iaddr = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic knobs(input int unsigned a, input int unsigned b, input int unsigned c,
                       input int unsigned d, input int unsigned e);
    p_inst = a; p_data = b; p_aok = c; p_dok = d; p_cancel = e;
  endtask

  // One clock cycle: drive inputs on the falling edge, compare against the model, advance the model.
  task automatic step();
    int sel;
    bit req, hs, pop_ok, e_iok, e_dok;
    @(negedge clk);
    if (!i_pend && ($urandom_range(99) < p_inst)) begin
      i_pend     = 1;
      inst_addr  = use_fix ? fix_iaddr : $urandom;
      inst_size  = 2'($urandom_range(2));
      inst_wstrb = 4'($urandom);
      inst_wdata = $urandom;
    end
    inst_req = i_pend;
    inst_wr  = 1'b0;
    if (!d_pend && ($urandom_range(99) < p_data)) begin
      d_pend     = 1;
      data_addr  = $urandom;
      data_wr    = 1'($urandom_range(1));
      data_size  = 2'($urandom_range(2));
      data_wstrb = 4'($urandom);
      data_wdata = $urandom;
    end
    data_req    = d_pend;
    mem_addr_ok = ($urandom_range(99) < p_aok);
    mem_data_ok = force_dok || ((mq_src.size() > 0) && ($urandom_range(99) < p_dok));
    inst_cancel = ($urandom_range(99) < p_cancel);
    mem_rdata   = $urandom;
    #1;
    req = 0;
    sel = SD;
    if (m_lock >= 0) begin
      req = 1; sel = m_lock;
    end else if (mq_src.size() < OUTSTANDING) begin
      if (data_req && (m_starve < MAX_STARVE)) begin req = 1; sel = SD; end
      else if (inst_req)                        begin req = 1; sel = SI; end
      else if (data_req)                        begin req = 1; sel = SD; end
    end
    hs     = req && mem_addr_ok;
    pop_ok = mem_data_ok && (mq_src.size() > 0);
    e_iok  = pop_ok && (mq_src[0] == SI) && !mq_canc[0] && !inst_cancel;
    e_dok  = pop_ok && (mq_src[0] == SD);
    check("mem_req", mem_req, req);
    if (req) begin
      check("mem_addr",  mem_addr, (sel == SI) ? inst_addr : data_addr);
      check("mem_ctl",   {mem_wr, mem_size, mem_wstrb},
            (sel == SI) ? {inst_wr, inst_size, inst_wstrb} : {data_wr, data_size, data_wstrb});
      check("mem_wdata", mem_wdata, (sel == SI) ? inst_wdata : data_wdata);
    end
    check("inst_addr_ok", inst_addr_ok, hs && (sel == SI));
    check("data_addr_ok", data_addr_ok, hs && (sel == SD));
    check("inst_data_ok", inst_data_ok, e_iok);
    check("data_data_ok", data_data_ok, e_dok);
    check("resp_err",     resp_err, m_err);
    check("inst_rdata",   inst_rdata, mem_rdata);
    check("data_rdata",   data_rdata, mem_rdata);
    obs_iok  = inst_data_ok;
    obs_dok  = data_data_ok;
    obs_iaok = inst_addr_ok;
    obs_daok = data_addr_ok;
    if (inst_addr_ok) obs_hist.push_back(SI);
    if (data_addr_ok) obs_hist.push_back(SD);
    if (mem_data_ok && (mq_src.size() == 0)) m_err = 1;
    if (pop_ok) begin
      void'(mq_src.pop_front());
      void'(mq_canc.pop_front());
    end
    if (inst_cancel) foreach (mq_canc[k]) if (mq_src[k] == SI) mq_canc[k] = 1;
    if (hs) begin
      mq_src.push_back(sel);
      mq_canc.push_back(inst_cancel && (sel == SI));
    end
    if (!inst_req || (hs && sel == SI)) m_starve = 0;
    else if (hs && m_starve < MAX_STARVE) m_starve++;
    if (m_lock < 0 && req && !mem_addr_ok) m_lock = sel;
    else if (m_lock >= 0 && mem_addr_ok)   m_lock = -1;
    if (hs && sel == SI) i_pend = 0;
    if (hs && sel == SD) d_pend = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; inst_cancel = 0;
    i_pend = 0; d_pend = 0; force_dok = 0;
    @(negedge clk);
    rst = 0;
    mq_src.delete(); mq_canc.delete();
    m_lock = -1; m_starve = 0; m_err = 0;
  endtask

  initial begin
    int t1_exp[8];
    t1_exp = '{SD, SD, SD, SI, SD, SD, SD, SI};
    do_reset();

    // Reset state
    knobs(0, 0, 0, 0, 0);
    step();
    check("rst_mem_req",  mem_req, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);

    // Scenario 1: both requesters saturated, starvation guard interleaves fetch
    obs_hist.delete();
    knobs(100, 100, 100, 100, 0);
    repeat (8) step();
    check("t1_count", obs_hist.size(), 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("t1_src%0d", k), (k < obs_hist.size()) ? obs_hist[k] : -1, t1_exp[k]);

    // Scenario 2: fetch locked while addr_ok is low, data waits its turn
    do_reset();
    use_fix = 1; fix_iaddr = 32'h1c00_0000;
    knobs(100, 0, 0, 0, 0);
    step();
    knobs(100, 100, 0, 0, 0);
    repeat (2) step();
    check("t2_req",  mem_req, 1'b1);
    check("t2_addr", mem_addr, 32'h1c00_0000);
    knobs(100, 100, 100, 0, 0);
    step();
    check("t2_inst_hs", obs_iaok, 1'b1);
    step();
    check("t2_data_hs", obs_daok, 1'b1);
    use_fix = 0;

    // Scenario 3: tracking FIFO full blocks grants; a pop frees a slot only next cycle
    do_reset();
    knobs(100, 0, 100, 0, 0);
    repeat (5) step();
    check("t3_full_block", mem_req, 1'b0);
    force_dok = 1;
    step();
    force_dok = 0;
    check("t3_same_cycle", mem_req, 1'b0);
    step();
    check("t3_resume", mem_req, 1'b1);

    // Scenario 4: cancel drops outstanding fetch responses, data unaffected
    do_reset();
    knobs(100, 0, 100, 0, 0);   step();
    knobs(0, 100, 100, 0, 0);   step();
    knobs(100, 0, 100, 0, 0);   step();
    knobs(0, 0, 0, 0, 100);     step();
    knobs(0, 0, 0, 100, 0);
    step(); check("t4_r1_iok", obs_iok, 1'b0); check("t4_r1_dok", obs_dok, 1'b0);
    step(); check("t4_r2_dok", obs_dok, 1'b1);
    step(); check("t4_r3_iok", obs_iok, 1'b0);
    knobs(100, 0, 100, 100, 0); step();
    knobs(0, 0, 0, 100, 0);     step();
    check("t4_new_iok", obs_iok, 1'b1);

    // Scenario 5: response with nothing outstanding, then reset mid-burst
    do_reset();
    knobs(0, 0, 0, 0, 0);
    force_dok = 1; step(); force_dok = 0;
    check("t5_no_iok", obs_iok, 1'b0);
    check("t5_no_dok", obs_dok, 1'b0);
    step();
    check("t5_err_set", resp_err, 1'b1);
    knobs(100, 100, 100, 0, 0);
    repeat (3) step();
    check("t5_err_sticky", resp_err, 1'b1);
    do_reset();
    knobs(0, 0, 0, 0, 0);
    step();
    check("t5_rst_err", resp_err, 1'b0);
    check("t5_rst_req", mem_req, 1'b0);
    force_dok = 1; step(); force_dok = 0;
    check("t5_flushed_dok", obs_dok, 1'b0);
    check("t5_flushed_iok", obs_iok, 1'b0);

    // Randomized run with periodically reshuffled traffic mix
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0)
        knobs($urandom_range(100), $urandom_range(100), $urandom_range(20, 100),
              $urandom_range(10, 100), $urandom_range(15));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one sram-like memory port between the fetch-side instruction requester and the memory-stage data requester.
- Fixed data-first priority, plus a starvation guard for instruction fetch.
- Locks the granted source until the downstream address handshake completes.
- Tracks outstanding transactions in order to route each data_ok/rdata back to its source.
- Supports instruction-response cancellation on redirect (branch/exception/ertn) so stale fetch data is dropped.

Parameters:
- OUTSTANDING, 4, max accepted-but-unanswered transactions (power of 2, ≥2)
- MAX_STARVE, 3, consecutive data grants allowed while inst_req is pending before inst is forced ahead

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- inst_req / inst_wr  in  1 / 1  instruction request; wr is always 0 from fetch but is still forwarded
- inst_size / inst_addr  in  2 / 32  instruction transfer size / address
- inst_wstrb / inst_wdata  in  4 / 32  instruction write strobe / data
- inst_addr_ok / inst_data_ok  out  1 / 1  instruction handshakes
- inst_rdata  out  32  instruction read data
- inst_cancel  in  1  drop the responses of all outstanding instruction transactions
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1,1,2,32,4,32  data-side request fields
- data_addr_ok / data_data_ok  out  1 / 1  data handshakes
- data_rdata  out  32  data read data
- mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1,1,2,32,4,32  downstream request
- mem_addr_ok / mem_data_ok  in  1 / 1  downstream handshakes
- mem_rdata  in  32  downstream read data
- resp_err  out  1  sticky flag: data_ok arrived with no outstanding entry

Behaviour:
- Requester rule: req and all its fields stay stable from assertion until addr_ok. The arbiter forwards them combinationally from the selected source.
- FSM (registered): IDLE, LOCK_I, LOCK_D; reset state is IDLE.
  - IDLE: select a source when the tracking FIFO count < OUTSTANDING.
    - Pick data if data_req and the starve counter < MAX_STARVE; otherwise pick inst if inst_req; otherwise pick data.
    - mem_req = 1 for the selected source.
    - If mem_addr_ok in the same cycle: complete and stay in IDLE. Else: go to LOCK_I or LOCK_D.
  - LOCK_x: mem_req = 1 with source x's fields, regardless of the other request or the FIFO count. On mem_addr_ok, go to IDLE.
- x_addr_ok = mem_addr_ok && mem_req && the selected source is x. The other source's addr_ok is 0.
- Starve counter (2+ bits, saturating at MAX_STARVE):
  - +1 on each data address handshake while inst_req = 1.
  - Cleared on an inst address handshake or when inst_req = 0.
- Tracking FIFO: OUTSTANDING entries of {src, cancelled}.
  - Push on an address handshake; pop on mem_data_ok.
  - Push and pop in the same cycle are both allowed.
  - Full is judged on the registered count only; a same-cycle pop does not unblock a grant.
- Cancellation: while inst_cancel = 1, set cancelled on every valid inst entry, including an inst entry pushed in that same cycle.
- Response routing, head entry h, in the same cycle as mem_data_ok (zero latency):
  - inst_data_ok = mem_data_ok && h.src == I && !h.cancelled && !inst_cancel
  - data_data_ok = mem_data_ok && h.src == D
  - inst_rdata = data_rdata = mem_rdata at all times.
- Empty FIFO with mem_data_ok: no pop, no data_ok is driven, resp_err <= 1 and stays set until rst.
- Reset values:
  - FSM = IDLE, FIFO empty, starve counter = 0, resp_err = 0.
  - Combinational outputs evaluate with the cleared state: mem_req = 0 while no req is present.
- Reset mid-operation: all outstanding entries are discarded. The downstream must also be reset, because later data_ok pulses would raise resp_err.
- Address widths pass through unmodified; the block does no alignment checks (fetch already raises ADEF).

Decomposition:
- Shared header (`Defines.vh`):
  - SRC_INST = 1'b0, SRC_DATA = 1'b1
  - FSM state encodings
  - sram-like bus field-width macros (size 2, strb 4, addr/data 32)
- One sub-module: arb_track_fifo, a small synchronous FIFO of {src, cancelled} with a bulk "cancel all inst entries" input, count, full and empty.

Test Plan:
1. Both reqs held from cycle 0, mem_addr_ok = 1 every cycle, data_ok 1 cycle later, OUTSTANDING = 4, MAX_STARVE = 3 -> accepted source order D,D,D,I,D,D,D,I; each data_ok routes to the matching source in order.
2. inst_req only, mem_addr_ok held low 3 cycles; data_req rises in cycle 1 -> mem_req stays on the inst address 0x1c000000 until addr_ok (LOCK_I); data is granted the cycle after.
3. 4 inst accepted, no data_ok -> mem_req = 0 on a 5th request; one mem_data_ok -> grant resumes the next cycle, not the same cycle.
4. Inst outstanding 2, data outstanding 1 (order I,D,I); pulse inst_cancel -> the three data_ok pulses give inst_data_ok = 0, data_data_ok = 1, inst_data_ok = 0; a new inst request after the cancel returns normally.
5. mem_data_ok with the FIFO empty -> no data_ok on either side, resp_err = 1 until rst; assert rst mid-burst with 3 outstanding -> FIFO empty, FSM IDLE, resp_err = 0 the next cycle.
